// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory access arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam logic [3:0] SRC_FETCH0 = 4'd8;
  localparam logic [3:0] SRC_FETCH1 = 4'd9;

  typedef struct packed {
    logic [3:0]  source;
    logic        is_stack;
    logic        is_write;
    logic        is_byte;
    logic [2:0]  size;
    logic [31:0] address;
  } issue_cmd_t;

  function automatic logic [3:0] fetch_source(input logic port);
    return port ? SRC_FETCH1 : SRC_FETCH0;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational 8-way round-robin select: first set req bit at or above ptr, wrapping 7->0.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       found,
  output logic [2:0] index
);

  logic [2:0] cand;

  always_comb begin
    found = 1'b0;
    index = 3'd0;
    cand  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the memory_interface request path between executer and instruction-fetch ports.
// One transaction at a time: grant, valid/ready issue, wait for mem_done, one-cycle ack.
//
// state     | meaning
// IDLE      | no transaction; choose a winner among eligible requesters
// ISSUE     | command held on the issue channel, waiting for issue_ready
// WAIT_DONE | command accepted, waiting for mem_done
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_EXECUTERS = 8,
  parameter int STARVE_LIMIT  = 4,
  parameter int FETCH_ADDR_W  = 26
) (
  input  logic                                main_clk,
  input  logic                                main_rst_n,
  input  logic [NUM_EXECUTERS-1:0]            ex_req_general,
  input  logic [NUM_EXECUTERS-1:0]            ex_req_stack,
  input  logic [NUM_EXECUTERS-1:0]            ex_is_write,
  input  logic [NUM_EXECUTERS-1:0]            ex_is_byte,
  input  logic [NUM_EXECUTERS-1:0][2:0]       ex_stack_size,
  input  logic [NUM_EXECUTERS-1:0][31:0]      ex_address,
  input  logic [1:0]                          if_req,
  input  logic [1:0][FETCH_ADDR_W-1:0]        if_address,
  input  logic                                void_instruction_fetch,
  output logic [NUM_EXECUTERS-1:0]            ack_executer,
  output logic [1:0]                          ack_fetch,
  output logic                                issue_valid,
  input  logic                                issue_ready,
  output logic [3:0]                          issue_source,
  output logic                                issue_is_stack,
  output logic                                issue_is_write,
  output logic                                issue_is_byte,
  output logic [2:0]                          issue_size,
  output logic [31:0]                         issue_address,
  input  logic                                mem_done,
  output logic                                busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t  state;
  issue_cmd_t  cmd;
  issue_cmd_t  next_cmd;
  logic [2:0]  rr_ptr;
  logic [SW-1:0] starve_cnt;
  logic        voided;
  logic        dropped;

  logic [NUM_EXECUTERS-1:0] ex_elig;
  logic [1:0]  f_elig;
  logic        ex_found;
  logic [2:0]  ex_idx;
  logic        take_fetch;
  logic        grant;

  logic        src_is_fetch;
  logic [2:0]  src_ex;
  logic        src_req;
  logic        suppress;
  logic [NUM_EXECUTERS-1:0] ack_ex_next;
  logic [1:0]  ack_f_next;

  assign ex_elig = ex_req_general | ex_req_stack;
  assign f_elig  = if_req & {2{~void_instruction_fetch}};

  rr_pick8 u_pick (
    .req   (ex_elig),
    .ptr   (rr_ptr),
    .found (ex_found),
    .index (ex_idx)
  );

  // Fetches normally win; executers take over once they have watched STARVE_LIMIT fetch grants.
  assign take_fetch = (|f_elig) && ((starve_cnt < STARVE_MAX) || !ex_found);
  assign grant      = take_fetch || ex_found;

  always_comb begin
    next_cmd = '0;
    if (take_fetch) begin
      next_cmd.source  = fetch_source(~f_elig[0]);
      next_cmd.address = 32'(f_elig[0] ? if_address[0] : if_address[1]);
      next_cmd.address[0] = 1'b0;
    end else begin
      next_cmd.source   = {1'b0, ex_idx};
      next_cmd.is_stack = ex_req_stack[ex_idx];
      next_cmd.is_write = ex_is_write[ex_idx];
      next_cmd.is_byte  = ex_req_stack[ex_idx] ? 1'b0 : ex_is_byte[ex_idx];
      next_cmd.size     = ex_req_stack[ex_idx] ? ex_stack_size[ex_idx] : 3'd0;
      next_cmd.address  = ex_address[ex_idx];
    end
  end

  assign src_is_fetch = cmd.source[3];
  assign src_ex       = cmd.source[2:0];
  assign src_req      = src_is_fetch ? if_req[cmd.source[0]] : ex_elig[src_ex];
  assign suppress     = src_is_fetch ? (voided | void_instruction_fetch) : (dropped | ~src_req);

  always_comb begin
    ack_ex_next = '0;
    ack_f_next  = '0;
    if (!suppress) begin
      if (src_is_fetch) ack_f_next[cmd.source[0]] = 1'b1;
      else              ack_ex_next[src_ex]       = 1'b1;
    end
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state        <= IDLE;
      cmd          <= '0;
      issue_valid  <= 1'b0;
      ack_executer <= '0;
      ack_fetch    <= '0;
      rr_ptr       <= 3'd0;
      starve_cnt   <= '0;
      voided       <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      ack_executer <= '0;
      ack_fetch    <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            cmd         <= next_cmd;
            issue_valid <= 1'b1;
            voided      <= 1'b0;
            dropped     <= 1'b0;
            state       <= ISSUE;
            if (take_fetch) begin
              if (!ex_found)                     starve_cnt <= '0;
              else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              rr_ptr     <= ex_idx + 3'd1;
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (mem_done) begin
              ack_executer <= ack_ex_next;
              ack_fetch    <= ack_f_next;
              state        <= IDLE;
            end else begin
              voided  <= src_is_fetch & void_instruction_fetch;
              dropped <= ~src_is_fetch & ~src_req;
              state   <= WAIT_DONE;
            end
          end else if (!src_req || (src_is_fetch && void_instruction_fetch)) begin
            issue_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (mem_done) begin
            ack_executer <= ack_ex_next;
            ack_fetch    <= ack_f_next;
            voided       <= 1'b0;
            dropped      <= 1'b0;
            state        <= IDLE;
          end else begin
            voided  <= voided  | (src_is_fetch & void_instruction_fetch);
            dropped <= dropped | (~src_is_fetch & ~src_req);
          end
        end
        default: begin
          issue_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign issue_source   = cmd.source;
  assign issue_is_stack = cmd.is_stack;
  assign issue_is_write = cmd.is_write;
  assign issue_is_byte  = cmd.is_byte;
  assign issue_size     = cmd.size;
  assign issue_address  = cmd.address;

  // A port raising both request kinds is served as a stack access.
  a_one_kind : assert property (@(posedge main_clk) disable iff (!main_rst_n)
    !(|(ex_req_general & ex_req_stack)))
    else $error("executer raised general and stack request together");

  a_done_ctx : assert property (@(posedge main_clk) disable iff (!main_rst_n)
    mem_done |-> (state != IDLE))
    else $warning("mem_done outside a transaction ignored");

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_access_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int FAW          = 26;

  logic             main_clk;
  logic             main_rst_n;
  logic [7:0]       ex_req_general, ex_req_stack, ex_is_write, ex_is_byte;
  logic [7:0][2:0]  ex_stack_size;
  logic [7:0][31:0] ex_address;
  logic [1:0]       if_req;
  logic [1:0][FAW-1:0] if_address;
  logic             void_instruction_fetch;
  logic [7:0]       ack_executer;
  logic [1:0]       ack_fetch;
  logic             issue_valid, issue_ready;
  logic [3:0]       issue_source;
  logic             issue_is_stack, issue_is_write, issue_is_byte;
  logic [2:0]       issue_size;
  logic [31:0]      issue_address;
  logic             mem_done, busy;

  mem_access_arbiter #(.NUM_EXECUTERS(8), .STARVE_LIMIT(STARVE_LIMIT), .FETCH_ADDR_W(FAW)) dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .ex_req_general(ex_req_general), .ex_req_stack(ex_req_stack),
    .ex_is_write(ex_is_write), .ex_is_byte(ex_is_byte),
    .ex_stack_size(ex_stack_size), .ex_address(ex_address),
    .if_req(if_req), .if_address(if_address),
    .void_instruction_fetch(void_instruction_fetch),
    .ack_executer(ack_executer), .ack_fetch(ack_fetch),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_source(issue_source), .issue_is_stack(issue_is_stack),
    .issue_is_write(issue_is_write), .issue_is_byte(issue_is_byte),
    .issue_size(issue_size), .issue_address(issue_address),
    .mem_done(mem_done), .busy(busy)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction record plus arbitration bookkeeping.
  bit          m_busy, m_acc, m_valid, m_voided, m_drop;
  int          m_src, m_rr, m_starve;
  logic        m_stk, m_wr, m_byte;
  logic [2:0]  m_size;
  logic [31:0] m_addr;
  logic [7:0]  m_ack_ex;
  logic [1:0]  m_ack_f;

  task automatic model_step();
    logic [7:0] elig;
    logic [1:0] fel;
    int k, p;
    bit is_f, live;
    elig = ex_req_general | ex_req_stack;
    fel  = void_instruction_fetch ? 2'b00 : if_req;
    is_f = (m_src >= 8);
    live = is_f ? if_req[m_src-8] : elig[m_src];
    m_ack_ex = '0;
    m_ack_f  = '0;
    if (!m_busy) begin
      k = -1;
      for (int i = 0; i < 8; i++)
        if (k < 0 && elig[(m_rr + i) % 8]) k = (m_rr + i) % 8;
      if (fel != 2'b00 && (m_starve < STARVE_LIMIT || k < 0)) begin
        p = fel[0] ? 0 : 1;
        m_src = 8 + p; m_stk = 0; m_wr = 0; m_byte = 0; m_size = 0;
        m_addr = 32'(if_address[p]) & 32'hFFFF_FFFE;
        m_starve = (k < 0) ? 0 : ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT);
        m_busy = 1; m_valid = 1; m_acc = 0; m_voided = 0; m_drop = 0;
      end else if (k >= 0) begin
        m_src  = k;
        m_stk  = ex_req_stack[k];
        m_wr   = ex_is_write[k];
        m_byte = m_stk ? 1'b0 : ex_is_byte[k];
        m_size = m_stk ? ex_stack_size[k] : 3'd0;
        m_addr = ex_address[k];
        m_rr = (k + 1) % 8; m_starve = 0;
        m_busy = 1; m_valid = 1; m_acc = 0; m_voided = 0; m_drop = 0;
      end
    end else begin
      if (!m_acc) begin
        if (issue_ready) begin
          m_valid = 0; m_acc = 1;
        end else if (!live || (is_f && void_instruction_fetch)) begin
          m_valid = 0; m_busy = 0;
        end
      end
      if (m_busy && m_acc) begin
        if (is_f && void_instruction_fetch) m_voided = 1;
        if (!is_f && !live) m_drop = 1;
        if (mem_done) begin
          if (is_f && !m_voided) m_ack_f[m_src-8] = 1'b1;
          if (!is_f && !m_drop)  m_ack_ex[m_src]  = 1'b1;
          m_busy = 0;
        end
      end
    end
  endtask

  always @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      m_busy = 0; m_acc = 0; m_valid = 0; m_voided = 0; m_drop = 0;
      m_src = 0; m_rr = 0; m_starve = 0;
      m_stk = 0; m_wr = 0; m_byte = 0; m_size = 0; m_addr = 0;
      m_ack_ex = 0; m_ack_f = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge main_clk) begin
    if (main_rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("valid", 32'(issue_valid), 32'(m_valid));
      check("ack", 32'({ack_fetch, ack_executer}), 32'({m_ack_f, m_ack_ex}));
      if (m_valid) begin
        check("source", 32'(issue_source), m_src);
        check("flags", 32'({issue_is_stack, issue_is_write, issue_is_byte, issue_size}),
              32'({m_stk, m_wr, m_byte, m_size}));
        check("address", issue_address, m_addr);
      end
    end
  end

  task automatic tick();
    @(negedge main_clk);
  endtask

  task automatic idle_inputs();
    ex_req_general = 0; ex_req_stack = 0; ex_is_write = 0; ex_is_byte = 0;
    ex_stack_size = '0; ex_address = '0; if_req = 0; if_address = '0;
    void_instruction_fetch = 0; issue_ready = 0; mem_done = 0;
  endtask

  task automatic do_reset();
    tick();
    main_rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    main_rst_n = 1'b1;
  endtask

  task automatic serve(output int src, output logic stk, output logic [9:0] ackv);
    int n;
    n = 0; src = -1; stk = 0; ackv = '0;
    issue_ready = 1'b1;
    while (!issue_valid && n < 50) begin tick(); n++; end
    if (!issue_valid) begin
      n_checks++; n_err++;
      $display("FAIL serve_timeout issue_valid=0 required=1 t=%0t", $time);
    end else begin
      src = int'(issue_source);
      stk = issue_is_stack;
      tick();
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      ackv = {ack_fetch, ack_executer};
    end
  endtask

  int src;
  logic stk;
  logic [9:0] ackv;
  int ex_cool[8];

  initial begin
    main_rst_n = 1'b0;
    idle_inputs();
    tick();
    check("reset_outputs", 32'({busy, issue_valid, ack_fetch, ack_executer}), 32'h0);
    main_rst_n = 1'b1;

    // single executer write
    tick();
    ex_req_general[3] = 1'b1; ex_address[3] = 32'h0000_1234; ex_is_write[3] = 1'b1;
    issue_ready = 1'b1;
    tick();
    check("t1_valid", 32'(issue_valid), 32'h1);
    check("t1_source", 32'(issue_source), 32'd3);
    check("t1_address", issue_address, 32'h1234);
    check("t1_write", 32'(issue_is_write), 32'h1);
    tick();
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("t1_ack", 32'(ack_executer), 32'h08);
    ex_req_general[3] = 1'b0;
    tick();
    check("t1_ack_once", 32'(ack_executer), 32'h00);
    check("t1_idle", 32'(busy), 32'h0);

    // round robin over all executers
    do_reset();
    for (int k = 0; k < 8; k++) ex_address[k] = $urandom;
    ex_req_general = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      serve(src, stk, ackv);
      check("rr_source", src, i % 8);
      check("rr_ack", 32'(ackv), 32'(10'b1 << (i % 8)));
      if (src >= 0 && src < 8) begin
        ex_req_general[src] = 1'b0;
        tick();
        ex_req_general[src] = 1'b1;
      end
    end
    ex_req_general = 8'h00;

    // fetch starvation limit
    do_reset();
    if_req[0] = 1'b1; if_address[0] = 26'h2AB_CDEF;
    ex_req_stack[5] = 1'b1; ex_stack_size[5] = 3'd5; ex_address[5] = 32'hCAFE_0010;
    for (int i = 0; i < 6; i++) begin
      serve(src, stk, ackv);
      check("starve_source", src, (i == 4) ? 5 : 8);
      if (i == 4) begin
        check("starve_stack", 32'(stk), 32'h1);
        ex_req_stack[5] = 1'b0;
      end
    end
    if_req = 2'b00;

    // void on an outstanding fetch, and void blocking a fetch grant
    do_reset();
    if_req[1] = 1'b1; if_address[1] = 26'h000_0457;
    issue_ready = 1'b1;
    tick();
    check("void_source", 32'(issue_source), 32'd9);
    check("void_addr", issue_address, 32'h456);
    tick();
    void_instruction_fetch = 1'b1;
    tick();
    void_instruction_fetch = 1'b0;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("void_ack", 32'(ack_fetch), 32'h0);
    void_instruction_fetch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("void_no_grant", 32'(issue_valid), 32'h0);
    end
    void_instruction_fetch = 1'b0; if_req = 2'b00;

    // withdrawal before acceptance
    do_reset();
    ex_req_general[6] = 1'b1; ex_req_general[7] = 1'b1;
    ex_address[6] = 32'h66; ex_address[7] = 32'h77;
    tick();
    check("wd_source", 32'(issue_source), 32'd6);
    ex_req_general[6] = 1'b0;
    tick();
    check("wd_valid_drop", 32'(issue_valid), 32'h0);
    check("wd_idle", 32'(busy), 32'h0);
    tick();
    check("wd_next", 32'(issue_source), 32'd7);
    serve(src, stk, ackv);
    check("wd_ack", 32'(ackv), 32'h080);
    ex_req_general[7] = 1'b0;

    // async reset during WAIT_DONE
    do_reset();
    ex_req_general[2] = 1'b1; issue_ready = 1'b1;
    tick();
    tick();
    check("ar_waiting", 32'({busy, issue_valid}), 32'h2);
    #2 main_rst_n = 1'b0;
    #1 check("ar_outputs", 32'({busy, issue_valid, ack_fetch, ack_executer}), 32'h0);
    tick();
    ex_req_general = 8'h00;
    main_rst_n = 1'b1;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("ar_stale_ack", 32'({ack_fetch, ack_executer}), 32'h0);
    tick();
    check("ar_stale_idle", 32'({busy, ack_fetch, ack_executer}), 32'h0);

    // random traffic
    do_reset();
    for (int k = 0; k < 8; k++) ex_cool[k] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int k = 0; k < 8; k++) begin
        if (ex_req_general[k] || ex_req_stack[k]) begin
          if (m_ack_ex[k] || $urandom_range(63) == 0) begin
            ex_req_general[k] = 1'b0; ex_req_stack[k] = 1'b0;
            ex_cool[k] = $urandom_range(20);
          end
        end else if (ex_cool[k] > 0) begin
          ex_cool[k]--;
        end else if ($urandom_range(7) == 0) begin
          if ($urandom_range(1) == 1) ex_req_stack[k] = 1'b1;
          else                        ex_req_general[k] = 1'b1;
          ex_is_write[k]   = 1'($urandom_range(1));
          ex_is_byte[k]    = 1'($urandom_range(1));
          ex_stack_size[k] = 3'($urandom_range(7));
          ex_address[k]    = $urandom;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (if_req[p]) begin
          if (m_ack_f[p] || $urandom_range(7) == 0) if_req[p] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          if_req[p] = 1'b1;
          if_address[p] = FAW'($urandom);
        end
      end
      void_instruction_fetch = ($urandom_range(15) == 0);
      issue_ready = 1'($urandom_range(1));
      mem_done = m_busy && (m_acc || issue_ready) && ($urandom_range(2) == 0);
    end
    idle_inputs();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Shares the single memory_interface request path between the 8 core_executer memory ports (general and stack accesses) and the 2 instruction_cache fetch ports. Selects one requester at a time and forwards its command on a valid/ready issue channel. Waits for the memory side's completion, then returns a one-cycle acknowledge pulse to the winning requester. Sits in core_main between the executer/instruction_cache request wires and memory_interface.

Parameters:
NUM_EXECUTERS, 8, number of executer request ports (source ids 0..NUM_EXECUTERS-1)
STARVE_LIMIT, 4, consecutive fetch grants allowed while any executer waits before executers win
FETCH_ADDR_W, 26, instruction fetch address width

Ports:
main_clk  in  1  clock
main_rst_n  in  1  async reset, active low
ex_req_general  in  8  executer general access request, level, held until ack
ex_req_stack  in  8  executer stack access request, level, held until ack
ex_is_write  in  8  per-executer write flag
ex_is_byte  in  8  per-executer byte-operation flag (general only)
ex_stack_size  in  8x3  per-executer stack access size
ex_address  in  8x32  per-executer target address
if_req  in  2  fetch port requests, level
if_address  in  2x26  fetch addresses
void_instruction_fetch  in  1  cancels outstanding fetch results
ack_executer  out  8  one-cycle completion pulse per executer
ack_fetch  out  2  one-cycle completion pulse per fetch port
issue_valid  out  1  command valid to memory_interface
issue_ready  in  1  memory_interface accepts command
issue_source  out  4  0-7 executer, 8/9 fetch port 0/1
issue_is_stack, issue_is_write, issue_is_byte  out  1 each  command flags
issue_size  out  3  stack size (0 for others)
issue_address  out  32  address (fetch zero-extended, bit0 forced 0)
mem_done  in  1  one-cycle completion pulse from memory_interface
busy  out  1  state != IDLE

Behaviour:
- Reset (async, main_rst_n=0): state IDLE; every output 0; rr_ptr=0; starve_cnt=0; voided=0. Asserting reset mid-transaction abandons it with no ack. memory_interface shares the reset.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE: an executer is eligible when ex_req_general|ex_req_stack is set. A fetch port is eligible when if_req is set and void_instruction_fetch=0.
- IDLE priority when fetches are eligible: fetch wins if starve_cnt<STARVE_LIMIT or no executer is eligible; port 0 beats port 1.
- IDLE priority otherwise: executer round-robin, searching from rr_ptr upward with wrap 7->0.
- IDLE on a winner: register the command fields and go to ISSUE; issue_valid=1 the next cycle, i.e. 1 cycle from request to valid.
- Executer with both req_general and req_stack set: assertion failure; treated as stack.
- Executer grant k: rr_ptr<=(k+1) mod 8, starve_cnt<=0.
- Fetch grant: if any executer is eligible, starve_cnt increments, saturating at STARVE_LIMIT; otherwise starve_cnt<=0.
- ISSUE: command fields are stable while issue_valid=1.
- ISSUE, issue_ready=1: valid drops next cycle and state goes to WAIT_DONE. If mem_done is also 1 in the same cycle, complete directly (see ack rule).
- ISSUE withdrawal, issue_ready=0: if the source request drops, or a fetch source sees void_instruction_fetch=1, return to IDLE with valid dropped and no ack.
- WAIT_DONE: on mem_done=1, the ack pulse is registered and appears the cycle after mem_done; state goes to IDLE in that same cycle. A new grant is possible in the cycle the ack is high, so back-to-back service has a 2-cycle gap from mem_done to the next issue_valid.
- mem_done outside ISSUE/WAIT_DONE: ignored, assertion failure.
- Void: void_instruction_fetch while a fetch is accepted/outstanding sets voided. The transaction still completes, ack_fetch is suppressed and voided clears on completion. Void has no effect on executer transactions.
- Executer request dropped after acceptance: the transaction completes and ack_executer is suppressed.
- At most one ack bit is high in any cycle; ack bits are never 1 in consecutive cycles for the same source.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef arb_state_t {IDLE, ISSUE, WAIT_DONE}
  - constants SRC_FETCH0=4'd8, SRC_FETCH1=4'd9
  - typedef issue_cmd_t {source, is_stack, is_write, is_byte, size, address}
- One sub-module rr_pick8: combinational 8-way round-robin select. Inputs req[7:0] and ptr[2:0]; outputs found and index[2:0].

Test Plan:
- Single executer: ex_req_general[3]=1, addr 32'h0000_1234, write, ready same cycle as valid, mem_done 2 cycles later -> issue_valid cycle+1, issue_source=3, issue_address=32'h1234, issue_is_write=1; ack_executer=8'h08 for exactly one cycle after mem_done; busy 0 afterward.
- Round-robin: ex_req_general=8'hFF held, each acked request dropped -> grant order 0,1,...,7,0; ack order matches.
- Starvation: if_req[0] held continuously with ex_req_stack[5]=1, STARVE_LIMIT=4 -> 4 fetch grants (source 8) then source 5 with issue_is_stack=1, then fetch resumes.
- Void: fetch port 1 accepted, void_instruction_fetch pulsed in WAIT_DONE, mem_done arrives -> ack_fetch stays 2'b00; a fetch request in a void cycle in IDLE is not granted.
- Withdrawal: executer 6 granted, issue_ready=0, ex_req_general[6] dropped -> issue_valid falls next cycle, state IDLE, no ack; pending executer 7 granted next.
- Async reset mid WAIT_DONE: main_rst_n low between clock edges -> all outputs 0 immediately; after release a stale mem_done causes no ack.
